uart_rx: RTL and testbench

- Serial receiver paired with the tx stage. It consumes the DATA_OUT_Tx line: start bit, 7/8 data bits LSB-first, optional parity bit, one stop bit.
- Oversamples the line at CLKS_PER_BIT system clocks per bit and samples each bit at mid-bit.
- Delivers the parallel byte with a one-cycle valid strobe, a sticky interrupt, and error flags.
- Sits between the pad/loopback line and the register interface.

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Host-side bus of the serial receiver: serial line in, frame config,
// host acknowledge, and the received byte with its status flags.
interface uart_rx_if;
  // Handshake: RX_VALID is a one-cycle strobe with no back-pressure; the byte
  // and flags it qualifies stay held afterwards. The host acknowledges a
  // delivered frame by pulsing UART_READ, which clears IRQ_Rx and OVERRUN.
  logic       DATA_IN_Rx;
  logic       UART_BITS;
  logic       UART_PARITY;
  logic       UART_PARITY_ODD;
  logic       UART_READ;
  logic [7:0] DATA_OUT_Rx;
  logic       RX_VALID;
  logic       IRQ_Rx;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       OVERRUN;

  modport master (
    output DATA_IN_Rx, UART_BITS, UART_PARITY, UART_PARITY_ODD, UART_READ,
    input  DATA_OUT_Rx, RX_VALID, IRQ_Rx, PARITY_ERR, FRAME_ERR, OVERRUN
  );

  modport slave (
    input  DATA_IN_Rx, UART_BITS, UART_PARITY, UART_PARITY_ODD, UART_READ,
    output DATA_OUT_Rx, RX_VALID, IRQ_Rx, PARITY_ERR, FRAME_ERR, OVERRUN
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, 7/8 data bits LSB-first, optional
// parity, one stop bit. Each bit is sampled at mid-bit after a two-flop
// synchronizer; completed frames raise a one-cycle strobe and a sticky IRQ.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       RST,
  uart_rx_if.slave   bus,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // Half period lands the first sample mid start bit; full periods thereafter.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_m;
  logic             rx_s;
  logic             rx_prev;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             cfg_bits8;
  logic             cfg_par;
  logic             cfg_odd;
  logic             par_acc;
  logic             par_bad;
  logic             tick;
  logic             fall;
  logic             done;
  logic [2:0]       last_idx;

  logic [7:0]       data_q;
  logic             valid_q;
  logic             irq_q;
  logic             perr_q;
  logic             ferr_q;
  logic             ovr_q;

  assign tick     = (cnt == '0);
  assign fall     = ~rx_s & rx_prev;
  assign done     = (state == S_STOP) & tick;
  assign last_idx = cfg_bits8 ? 3'd7 : 3'd6;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (RST) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= bus.DATA_IN_Rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM: bit-period counter, shift register and parity accumulation
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      cfg_bits8 <= 1'b0;
      cfg_par   <= 1'b0;
      cfg_odd   <= 1'b0;
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fall) begin
            state     <= S_START;
            cnt       <= HALF_M1;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            cfg_bits8 <= bus.UART_BITS;
            cfg_par   <= bus.UART_PARITY;
            cfg_odd   <= bus.UART_PARITY_ODD;
          end
        end
        S_START: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            // Line went back high by mid start bit: treat as a glitch
            state <= S_IDLE;
          end else begin
            state <= S_DATA;
            cnt   <= FULL_M1;
          end
        end
        S_DATA: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg[bit_idx] <= rx_s;
            par_acc        <= par_acc ^ rx_s;
            cnt            <= FULL_M1;
            if (bit_idx == last_idx) begin
              state <= cfg_par ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            par_bad <= (par_acc ^ rx_s) != cfg_odd;
            state   <= S_STOP;
            cnt     <= FULL_M1;
          end
        end
        S_STOP: begin
          if (!tick) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= rx_s ? S_IDLE : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Completion outputs, sticky interrupt and overrun tracking
  always_ff @(posedge clk) begin
    if (RST) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) begin
        data_q <= shreg;
        perr_q <= cfg_par & par_bad;
        ferr_q <= ~rx_s;
      end
      // A completion in the same cycle as a read keeps the interrupt set
      if (done) begin
        irq_q <= 1'b1;
      end else if (bus.UART_READ) begin
        irq_q <= 1'b0;
      end
      if (done && irq_q && !bus.UART_READ) begin
        ovr_q <= 1'b1;
      end else if (bus.UART_READ) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.DATA_OUT_Rx = data_q;
  assign bus.RX_VALID    = valid_q;
  assign bus.IRQ_Rx      = irq_q;
  assign bus.PARITY_ERR  = perr_q;
  assign bus.FRAME_ERR   = ferr_q;
  assign bus.OVERRUN     = ovr_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, multi-cycle corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;

  localparam int         CPB     = 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam int         NV      = 8;

  typedef struct {
    logic [7:0] data;
    logic       b8;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stopb;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  // Expected strobes: {strobe cycle[41:10], data[9:2], perr[1], ferr[0]}
  logic [41:0] exp_q[$];
  vec_t        vecs[NV];

  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk       (clk),
    .RST       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    bus.DATA_IN_Rx = v;
    repeat (CPB) tick();
  endtask

  task automatic do_read();
    bus.UART_READ = 1'b1;
    tick();
    bus.UART_READ = 1'b0;
  endtask

  // Frame-level reference: what a receiver must deliver for a given frame
  function automatic logic [9:0] ref_model(input logic [7:0] d, input logic b8,
                                           input logic pen, input logic podd,
                                           input logic pbit, input logic stopb);
    int         n;
    int         ones;
    logic [7:0] data;
    logic       perr;
    n    = b8 ? 8 : 7;
    ones = 0;
    data = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        data = data + 8'(1 << i);
        ones++;
      end
    end
    if (pbit) ones++;
    perr = pen && ((ones % 2) != (podd ? 1 : 0));
    return {data, perr, ~stopb};
  endfunction

  // Drives one frame; must be called just after a rising edge (tick alignment)
  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen,
                            input logic podd, input logic pbit, input logic stopb,
                            input bit push, input logic [7:0] ed, input logic ep,
                            input logic ef);
    int n;
    int c;
    n = b8 ? 8 : 7;
    bus.UART_BITS       = b8;
    bus.UART_PARITY     = pen;
    bus.UART_PARITY_ODD = podd;
    c = cyc;
    // Line first sampled low at edge c+1, detected 2 edges later, stop sample
    // half a bit plus (N+P+1) bit periods after detection.
    if (push) exp_q.push_back({32'(c + 3 + CPB / 2 + (n + (pen ? 1 : 0) + 1) * CPB), ed, ep, ef});
    drive_bit(1'b0);
    // Config changes after the start bit must not affect this frame
    bus.UART_BITS       = 1'($urandom_range(0, 1));
    bus.UART_PARITY     = 1'($urandom_range(0, 1));
    bus.UART_PARITY_ODD = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(stopb);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : scoreboard
    logic [41:0] e;
    if (exp_q.size() > 0 && cyc > int'(exp_q[0][41:10])) begin
      e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missed_strobe: no RX_VALID by cycle %0d, expected at %0d", cyc, e[41:10]);
    end
    if (bus.RX_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: RX_VALID=1 at cycle %0d, expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", 32'(cyc), e[41:10]);
        chk("strobe_data", 32'(bus.DATA_OUT_Rx), 32'(e[9:2]));
        chk("strobe_perr", 32'(bus.PARITY_ERR), 32'(e[1]));
        chk("strobe_ferr", 32'(bus.FRAME_ERR), 32'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       b8, pen, podd, pbit, stopb;
    logic [9:0] r;
    int         c0;
    int         s2;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h53, 1'b0, 1'b0};
    vecs[2] = '{8'h53, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h53, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[7] = '{8'hD5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};

    bus.DATA_IN_Rx      = 1'b1;
    bus.UART_BITS       = 1'b1;
    bus.UART_PARITY     = 1'b0;
    bus.UART_PARITY_ODD = 1'b0;
    bus.UART_READ       = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_data", 32'(bus.DATA_OUT_Rx), 32'h00);
    chk("rst_valid", 32'(bus.RX_VALID), 32'd0);
    chk("rst_irq", 32'(bus.IRQ_Rx), 32'd0);
    chk("rst_perr", 32'(bus.PARITY_ERR), 32'd0);
    chk("rst_ferr", 32'(bus.FRAME_ERR), 32'd0);
    chk("rst_ovr", 32'(bus.OVERRUN), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Table-driven frames, each acknowledged by a read
    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].data, vecs[i].b8, vecs[i].pen, vecs[i].podd, vecs[i].pbit,
                 vecs[i].stopb, 1'b1, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      @(negedge clk);
      chk($sformatf("tbl%0d_irq", i), 32'(bus.IRQ_Rx), 32'd1);
      chk($sformatf("tbl%0d_ovr", i), 32'(bus.OVERRUN), 32'd0);
      chk($sformatf("tbl%0d_hold", i), 32'(bus.DATA_OUT_Rx), 32'(vecs[i].exp_data));
      tick();
      do_read();
      @(negedge clk);
      chk($sformatf("tbl%0d_irq_clr", i), 32'(bus.IRQ_Rx), 32'd0);
      tick();
    end

    // Glitch: 4 clocks low is rejected, flags keep the last frame's values
    bus.DATA_IN_Rx = 1'b0;
    repeat (4) tick();
    bus.DATA_IN_Rx = 1'b1;
    repeat (12 * CPB) tick();
    @(negedge clk);
    chk("glitch_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("glitch_data", 32'(bus.DATA_OUT_Rx), 32'h55);
    chk("glitch_irq", 32'(bus.IRQ_Rx), 32'd0);
    chk("glitch_perr", 32'(bus.PARITY_ERR), 32'd0);
    tick();

    // Break: stop bit 0 then line held low for 40 bit times
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (40 * CPB) tick();
    @(negedge clk);
    chk("break_ferr", 32'(bus.FRAME_ERR), 32'd1);
    chk("break_irq", 32'(bus.IRQ_Rx), 32'd1);
    chk("break_not_idle", 32'(dbg_state != ST_IDLE), 32'd1);
    tick();
    bus.DATA_IN_Rx = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("break_release_idle", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    do_read();
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_break_ferr", 32'(bus.FRAME_ERR), 32'd0);
    tick();
    do_read();
    tick();

    // Back-to-back without read: overrun
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_data", 32'(bus.DATA_OUT_Rx), 32'h22);
    chk("b2b_ovr", 32'(bus.OVERRUN), 32'd1);
    chk("b2b_irq", 32'(bus.IRQ_Rx), 32'd1);
    tick();
    do_read();
    @(negedge clk);
    chk("b2b_irq_clr", 32'(bus.IRQ_Rx), 32'd0);
    chk("b2b_ovr_clr", 32'(bus.OVERRUN), 32'd0);
    tick();

    // Back-to-back with the read landing on the second completion edge
    c0 = cyc;
    s2 = c0 + 10 * CPB + 3 + CPB / 2 + 9 * CPB;
    fork
      begin
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
      end
      begin
        while (cyc < s2 - 1) tick();
        bus.UART_READ = 1'b1;
        tick();
        bus.UART_READ = 1'b0;
      end
    join
    @(negedge clk);
    chk("coinc_irq", 32'(bus.IRQ_Rx), 32'd1);
    chk("coinc_ovr", 32'(bus.OVERRUN), 32'd0);
    tick();
    do_read();
    @(negedge clk);
    chk("coinc_irq_clr", 32'(bus.IRQ_Rx), 32'd0);
    tick();

    // Reset in the middle of the data bits of 0xFF, then a clean 0x5A
    fork
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      begin
        repeat (4 * CPB) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data", 32'(bus.DATA_OUT_Rx), 32'h00);
        chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("midrst_irq", 32'(bus.IRQ_Rx), 32'd0);
      end
    join
    tick();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_irq", 32'(bus.IRQ_Rx), 32'd1);
    tick();
    do_read();

    // Randomized frames against the reference model
    for (int k = 0; k < 12; k++) begin
      d     = 8'($urandom_range(0, 255));
      b8    = 1'($urandom_range(0, 1));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      pbit  = 1'($urandom_range(0, 1));
      stopb = ($urandom_range(0, 7) != 0);
      r = ref_model(d, b8, pen, podd, pbit, stopb);
      send_frame(d, b8, pen, podd, pbit, stopb, 1'b1, r[9:2], r[1], r[0]);
      bus.DATA_IN_Rx = 1'b1;
      repeat ($urandom_range(2, 4)) tick();
      do_read();
    end

    repeat (3 * CPB) tick();
    while (exp_q.size() > 0) begin
      r = exp_q[0][9:0];
      void'(exp_q.pop_front());
      n_checks++;
      n_errors++;
      $display("FAIL pending_strobe: expected frame data %0h never delivered", r[9:2]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
